// File: rtl/sram_boot_loader.sv
// Length-prefixed byte-stream loader for the 512x16 instruction SRAM.
// Owns the SRAM port until the image is in, then hands it to the CPU.
module sram_boot_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  reload,
  input  logic                  cpu_csb0,
  input  logic                  cpu_web0,
  input  logic [ADDR_WIDTH-1:0] cpu_addr0,
  input  logic [DATA_WIDTH-1:0] cpu_din0,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  done,
  output logic                  err
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [15:0] MAX_LEN = 16'(1 << ADDR_WIDTH);

  typedef enum logic [2:0] {
    HDR_LO, HDR_HI, DAT_LO, DAT_HI, FLUSH, DONE, ERR
  } state_t;

  state_t state, state_nx;

  logic                  xfer;
  logic [15:0]           hdr_len;
  logic [7:0]            len_lo;
  logic [7:0]            lo_q;
  logic [CW-1:0]         len;
  logic [CW-1:0]         wcnt;
  logic [CW-1:0]         wcnt_inc;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_din_q;
  logic                  own_cpu;

  assign xfer     = rx_valid && rx_ready;
  assign hdr_len  = {rx_data, len_lo};
  assign wcnt_inc = wcnt + 1'b1;
  assign own_cpu  = (state == DONE);

  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      state <= HDR_LO;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    rx_ready = 1'b1;
    unique case (state)
      HDR_LO: if (xfer) state_nx = HDR_HI;
      HDR_HI: begin
        if (xfer) begin
          if (hdr_len == 16'd0) begin
            state_nx = DONE;
          end else if (hdr_len > MAX_LEN) begin
            state_nx = ERR;
          end else begin
            state_nx = DAT_LO;
          end
        end
      end
      DAT_LO: if (xfer) state_nx = DAT_HI;
      DAT_HI: begin
        if (xfer) begin
          state_nx = (wcnt_inc == len) ? FLUSH : DAT_LO;
        end
      end
      FLUSH: begin
        rx_ready = 1'b0;
        state_nx = DONE;
      end
      DONE: begin
        rx_ready = 1'b0;
        if (reload) state_nx = HDR_LO;
      end
      ERR: if (reload) state_nx = HDR_LO;
      default: state_nx = HDR_LO;
    endcase
  end

  // Write pulse is registered so address/data are stable for a full cycle.
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      len_lo    <= '0;
      lo_q      <= '0;
      len       <= '0;
      wcnt      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_din_q  <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (xfer) begin
        case (state)
          HDR_LO: len_lo <= rx_data;
          HDR_HI: begin
            len  <= hdr_len[CW-1:0];
            wcnt <= '0;
          end
          DAT_LO: lo_q <= rx_data;
          DAT_HI: begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= wcnt[ADDR_WIDTH-1:0];
            wr_din_q  <= {rx_data, lo_q};
            wcnt      <= wcnt_inc;
          end
          default: ;
        endcase
      end
    end
  end

  assign sram_csb0  = own_cpu ? cpu_csb0  : !wr_en_q;
  assign sram_web0  = own_cpu ? cpu_web0  : !wr_en_q;
  assign sram_addr0 = own_cpu ? cpu_addr0 : wr_addr_q;
  assign sram_din0  = own_cpu ? cpu_din0  : wr_din_q;
  assign done       = own_cpu;
  assign err        = (state == ERR);

endmodule
